// File: rtl/axil_led_pkg.sv
// rtl/axil_led_pkg.sv - shared types, register offsets and response codes for axil_led_ctrl
package axil_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        AXI_IDLE = 2'd0,
        AXI_ACK  = 2'd1,
        AXI_RESP = 2'd2
    } axi_state_e;

    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_STATUS = 32'h04;
    localparam logic [31:0] OFF_PRESC  = 32'h08;
    localparam logic [31:0] OFF_CH0    = 32'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/axil_led_channel.sv
// rtl/axil_led_channel.sv - one LED timing generator: off, on, blink or PWM from the shared tick
module axil_led_channel
    import axil_led_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  led_mode_e mode,
    input  logic [7:0] duty,
    input  logic [7:0] half,
    input  logic      tick,
    input  logic      clr,
    output logic      led
);

    logic [7:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;
    logic       led_q, led_d;
    logic [7:0] half_last;

    always_comb begin
        half_last = (half == 8'd0) ? 8'd0 : half - 8'd1;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        if (!en || clr) begin
            cnt_d   = 8'd0;
            phase_d = 1'b0;
        end else if (tick) begin
            case (mode)
                // >= so a HALF shrunk below the running count still wraps promptly
                MODE_BLINK: begin
                    if (cnt_q >= half_last) begin
                        cnt_d   = 8'd0;
                        phase_d = ~phase_q;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                MODE_PWM: cnt_d = cnt_q + 8'd1;
                default:  cnt_d = cnt_q;
            endcase
        end
    end

    always_comb begin
        led_d = 1'b0;
        if (en) begin
            case (mode)
                MODE_ON:    led_d = 1'b1;
                MODE_BLINK: led_d = phase_q;
                MODE_PWM:   led_d = (cnt_q < duty);
                default:    led_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 8'd0;
            phase_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/axil_led_ctrl.sv
// rtl/axil_led_ctrl.sv - AXI4-Lite LED controller: register file, prescaler, AXI handshakes
module axil_led_ctrl
    import axil_led_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int PRESC_W    = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [NUM_CH-1:0]     led_o
);

    axi_state_e         wr_st_q, wr_st_d, rd_st_q, rd_st_d;
    logic [1:0]         bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               en_q, en_d;
    logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
    led_mode_e          mode_q [NUM_CH];
    led_mode_e          mode_d [NUM_CH];
    logic [7:0]         duty_q [NUM_CH];
    logic [7:0]         duty_d [NUM_CH];
    logic [7:0]         half_q [NUM_CH];
    logic [7:0]         half_d [NUM_CH];
    logic [NUM_CH-1:0]  clr, led;
    logic               tick, wr_fire;
    logic [31:0]        wr_word, rd_word, wr_idx, rd_idx, wmask, rd_val;
    logic               wr_ch_hit, rd_ch_hit, wr_ok, rd_ok;
    logic               unused;

    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA};

    // Word-granular decode; the byte lane bits of the address carry no meaning here.
    assign wr_word   = 32'(S_AXI_AWADDR[ADDR_WIDTH-1:2]);
    assign rd_word   = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:2]);
    assign wr_idx    = wr_word - (OFF_CH0 >> 2);
    assign rd_idx    = rd_word - (OFF_CH0 >> 2);
    assign wr_ch_hit = (wr_word >= (OFF_CH0 >> 2)) && (wr_idx < 32'(NUM_CH));
    assign rd_ch_hit = (rd_word >= (OFF_CH0 >> 2)) && (rd_idx < 32'(NUM_CH));
    assign wr_ok     = (wr_word == (OFF_CTRL >> 2)) || (wr_word == (OFF_STATUS >> 2)) ||
                       (wr_word == (OFF_PRESC >> 2)) || wr_ch_hit;
    assign wmask     = strb_mask(S_AXI_WSTRB);
    assign wr_fire   = (wr_st_q == AXI_ACK);

    assign tick   = en_q && (pcnt_q >= presc_q);
    assign pcnt_d = (!en_q || tick) ? '0 : pcnt_q + PRESC_W'(1);

    always_comb begin
        en_d    = en_q;
        presc_d = presc_q;
        clr     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            mode_d[k] = mode_q[k];
            duty_d[k] = duty_q[k];
            half_d[k] = half_q[k];
        end
        if (wr_fire) begin
            if (wr_word == (OFF_CTRL >> 2) && S_AXI_WSTRB[0]) en_d = S_AXI_WDATA[0];
            if (wr_word == (OFF_PRESC >> 2))
                presc_d = (presc_q & ~wmask[PRESC_W-1:0]) | (S_AXI_WDATA[PRESC_W-1:0] & wmask[PRESC_W-1:0]);
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_ch_hit && wr_idx == 32'(k)) begin
                    if (S_AXI_WSTRB[0]) begin
                        mode_d[k] = led_mode_e'(S_AXI_WDATA[1:0]);
                        clr[k]    = (S_AXI_WDATA[1:0] != mode_q[k]);
                    end
                    if (S_AXI_WSTRB[1]) duty_d[k] = S_AXI_WDATA[15:8];
                    if (S_AXI_WSTRB[2]) half_d[k] = S_AXI_WDATA[23:16];
                end
            end
        end
    end

    always_comb begin
        rd_val = 32'd0;
        rd_ok  = 1'b1;
        if (rd_word == (OFF_CTRL >> 2))        rd_val = {31'd0, en_q};
        else if (rd_word == (OFF_STATUS >> 2)) rd_val = 32'(led);
        else if (rd_word == (OFF_PRESC >> 2))  rd_val = 32'(presc_q);
        else if (rd_ch_hit) begin
            for (int k = 0; k < NUM_CH; k++)
                if (rd_idx == 32'(k)) rd_val = {8'd0, half_q[k], duty_q[k], 6'd0, mode_q[k]};
        end else rd_ok = 1'b0;
    end

    always_comb begin
        wr_st_d = wr_st_q;
        bresp_d = bresp_q;
        case (wr_st_q)
            AXI_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) wr_st_d = AXI_ACK;
            AXI_ACK: begin
                wr_st_d = AXI_RESP;
                bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
            AXI_RESP: if (S_AXI_BREADY) wr_st_d = AXI_IDLE;
            default:  wr_st_d = AXI_IDLE;
        endcase
    end

    // Read data is sampled in the ARREADY cycle, before any same-cycle write lands.
    always_comb begin
        rd_st_d = rd_st_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        case (rd_st_q)
            AXI_IDLE: if (S_AXI_ARVALID) rd_st_d = AXI_ACK;
            AXI_ACK: begin
                rd_st_d = AXI_RESP;
                rdata_d = rd_val;
                rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            AXI_RESP: if (S_AXI_RREADY) rd_st_d = AXI_IDLE;
            default:  rd_st_d = AXI_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_st_q <= AXI_IDLE;
            rd_st_q <= AXI_IDLE;
            bresp_q <= 2'b00;
            rresp_q <= 2'b00;
            rdata_q <= 32'd0;
            en_q    <= 1'b0;
            presc_q <= '0;
            pcnt_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                mode_q[k] <= MODE_OFF;
                duty_q[k] <= 8'd0;
                half_q[k] <= 8'd0;
            end
        end else begin
            wr_st_q <= wr_st_d;
            rd_st_q <= rd_st_d;
            bresp_q <= bresp_d;
            rresp_q <= rresp_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            for (int k = 0; k < NUM_CH; k++) begin
                mode_q[k] <= mode_d[k];
                duty_q[k] <= duty_d[k];
                half_q[k] <= half_d[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        axil_led_channel u_ch (
            .clk   (ACLK),
            .rst_n (ARESETN),
            .en    (en_q),
            .mode  (mode_q[k]),
            .duty  (duty_q[k]),
            .half  (half_q[k]),
            .tick  (tick),
            .clr   (clr[k]),
            .led   (led[k])
        );
    end

    assign S_AXI_AWREADY = (wr_st_q == AXI_ACK);
    assign S_AXI_WREADY  = (wr_st_q == AXI_ACK);
    assign S_AXI_BVALID  = (wr_st_q == AXI_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = (rd_st_q == AXI_ACK);
    assign S_AXI_RVALID  = (rd_st_q == AXI_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign led_o         = led;

endmodule

// File: tb/tb_axil_led_ctrl.sv
// tb/tb_axil_led_ctrl.sv - directed self-checking bench for axil_led_ctrl
module tb_axil_led_ctrl;

    localparam int NUM_CH = 8;
    localparam int AW     = 7;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic [AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]    S_AXI_AWPROT, S_AXI_ARPROT;
    logic          S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0]   S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]    S_AXI_WSTRB;
    logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
    logic          S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic          S_AXI_RVALID, S_AXI_RREADY;
    logic [NUM_CH-1:0] led_o;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0] rd;
    logic [1:0]  rs;
    int          n, hi;

    always #5 ACLK = ~ACLK;

    axil_led_ctrl #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .PRESC_W(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .led_o(led_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int c);
        repeat (c) @(posedge ACLK);
        #1;
    endtask

    task automatic finish_write(output logic [1:0] resp);
        int w = 0;
        while (!S_AXI_AWREADY && w < 20) begin cyc(1); w++; end
        chk("aw_w_ready", {31'd0, S_AXI_AWREADY & S_AXI_WREADY}, 32'd1);
        cyc(1);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b1;
        w = 0;
        while (!S_AXI_BVALID && w < 20) begin cyc(1); w++; end
        chk("bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
        resp = S_AXI_BRESP;
        cyc(1);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        finish_write(resp);
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int w = 0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && w < 20) begin cyc(1); w++; end
        chk("arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        cyc(1);
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        w = 0;
        while (!S_AXI_RVALID && w < 20) begin cyc(1); w++; end
        chk("rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        d    = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        cyc(1);
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic wait_change(output int cycles);
        logic prev = led_o[0];
        cycles = 0;
        while (led_o[0] == prev && cycles < 100) begin cyc(1); cycles++; end
    endtask

    task automatic count_high(input int bit_i, output int cnt);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            if (led_o[bit_i]) cnt++;
        end
    endtask

    initial begin
        ARESETN = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'd0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        cyc(3);
        chk("rst_ready", {28'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, 1'b0}, 32'd0);
        chk("rst_valid", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
        chk("rst_resp", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
        chk("rst_rdata", S_AXI_RDATA, 32'd0);
        chk("rst_led", 32'(led_o), 32'd0);
        ARESETN = 1'b1;
        cyc(2);

        axi_read(7'h00, rd, rs);
        chk("ctrl_rst_val", rd, 32'd0);
        axi_write(7'h00, 32'h1, 4'hF, rs);    chk("wr_ctrl_resp", 32'(rs), 32'd0);
        axi_write(7'h08, 32'h3, 4'hF, rs);    chk("wr_presc_resp", 32'(rs), 32'd0);
        axi_write(7'h10, 32'h2, 4'hF, rs);    chk("wr_ch0_resp", 32'(rs), 32'd0);
        axi_read(7'h00, rd, rs);  chk("rd_ctrl", rd, 32'h1);  chk("rd_ctrl_resp", 32'(rs), 32'd0);
        axi_read(7'h08, rd, rs);  chk("rd_presc", rd, 32'h3); chk("rd_presc_resp", 32'(rs), 32'd0);
        axi_read(7'h10, rd, rs);  chk("rd_ch0", rd, 32'h2);

        // PRESC=3, HALF=0: toggle every 4 cycles; HALF=3: every 12 cycles
        wait_change(n);
        wait_change(n);  chk("blink_half0", 32'(n), 32'd4);
        wait_change(n);  chk("blink_half0_b", 32'(n), 32'd4);
        axi_write(7'h10, 32'h0003_0002, 4'hF, rs);
        wait_change(n);
        wait_change(n);  chk("blink_half3", 32'(n), 32'd12);
        wait_change(n);  chk("blink_half3_b", 32'(n), 32'd12);

        axi_write(7'h14, 32'hFFFF_FFFF, 4'b0010, rs);
        axi_read(7'h14, rd, rs);  chk("ch1_strb", rd, 32'h0000_FF00);

        axi_write(7'h0C, 32'hFFFF_FFFF, 4'hF, rs);  chk("wr_0c_slverr", 32'(rs), 32'd2);
        axi_write(7'h30, 32'hFFFF_FFFF, 4'hF, rs);  chk("wr_30_slverr", 32'(rs), 32'd2);
        axi_read(7'h0C, rd, rs);  chk("rd_0c_data", rd, 32'd0);  chk("rd_0c_resp", 32'(rs), 32'd2);
        axi_read(7'h30, rd, rs);  chk("rd_30_data", rd, 32'd0);  chk("rd_30_resp", 32'(rs), 32'd2);
        axi_read(7'h00, rd, rs);  chk("ctrl_kept", rd, 32'h1);
        axi_read(7'h08, rd, rs);  chk("presc_kept", rd, 32'h3);
        axi_read(7'h14, rd, rs);  chk("ch1_kept", rd, 32'h0000_FF00);

        axi_write(7'h04, 32'hFFFF_FFFF, 4'hF, rs);  chk("wr_status_okay", 32'(rs), 32'd0);
        axi_write(7'h1C, 32'h1, 4'hF, rs);
        cyc(3);
        axi_read(7'h04, rd, rs);  chk("status_ch3_on", rd & 32'hFFFF_FFFE, 32'h8);

        axi_write(7'h08, 32'h0, 4'hF, rs);
        axi_write(7'h18, 32'h0000_4003, 4'hF, rs);
        cyc(4);
        count_high(2, hi);  chk("pwm_duty64", 32'(hi), 32'd64);
        axi_write(7'h18, 32'h0000_0003, 4'hF, rs);
        cyc(4);
        count_high(2, hi);  chk("pwm_duty0", 32'(hi), 32'd0);

        axi_write(7'h00, 32'h0, 4'hF, rs);
        cyc(3);
        chk("en0_led_off", 32'(led_o), 32'd0);
        axi_write(7'h28, 32'h1, 4'hF, rs);  chk("wr_en0_okay", 32'(rs), 32'd0);
        axi_write(7'h00, 32'h1, 4'hF, rs);
        cyc(3);
        chk("en1_ch3_ch6", 32'(led_o & 8'h48), 32'h48);

        // Second write must stall behind an unacknowledged B
        S_AXI_AWADDR = 7'h20; S_AXI_WDATA = 32'h11; S_AXI_WSTRB = 4'b0001;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 20) begin cyc(1); n++; end
        chk("hold_first_accept", {31'd0, S_AXI_AWREADY}, 32'd1);
        cyc(1);
        S_AXI_AWADDR = 7'h24; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (S_AXI_AWREADY || S_AXI_WREADY) hi++;
        end
        chk("hold_no_accept", 32'(hi), 32'd0);
        chk("hold_bvalid", {30'd0, S_AXI_BVALID, S_AXI_BRESP[1]}, 32'h2);
        S_AXI_BREADY = 1'b1;
        cyc(1);
        S_AXI_BREADY = 1'b0;
        finish_write(rs);  chk("second_wr_resp", 32'(rs), 32'd0);
        axi_read(7'h20, rd, rs);  chk("ch4_val", rd, 32'h1);
        axi_read(7'h24, rd, rs);  chk("ch5_val", rd, 32'h1);

        // Reset in the middle of a pending read response
        S_AXI_ARADDR = 7'h00; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin cyc(1); n++; end
        cyc(1);
        S_AXI_ARVALID = 1'b0;
        chk("pre_rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
        chk("pre_rst_led6", {31'd0, led_o[6]}, 32'd1);
        #2 ARESETN = 1'b0;
        #1;
        chk("async_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("async_led", 32'(led_o), 32'd0);
        cyc(2);
        ARESETN = 1'b1;
        cyc(2);
        axi_read(7'h00, rd, rs);  chk("post_rst_ctrl", rd, 32'd0);
        axi_read(7'h08, rd, rs);  chk("post_rst_presc", rd, 32'd0);
        axi_read(7'h10, rd, rs);  chk("post_rst_ch0", rd, 32'd0);
        axi_read(7'h28, rd, rs);  chk("post_rst_ch6", rd, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
